result_display_driver: RTL



---
 rtl/calc_display_pkg.sv | 30 +++
 rtl/seg7_encode.sv | 30 +++
 rtl/result_display_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/calc_display_pkg.sv
// Shared constants for the calculator result display: FSM state codes,
// BCD sizing and active-low seven-segment glyphs ordered {g,f,e,d,c,b,a}.
package calc_display_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a nibble of 5 or more overflows past 9 once doubled.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low seven-segment pattern, with a
// blank override. Codes above 9 render blank.
module seg7_encode
    import calc_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0: seg = SEG_0;
                4'd1: seg = SEG_1;
                4'd2: seg = SEG_2;
                4'd3: seg = SEG_3;
                4'd4: seg = SEG_4;
                4'd5: seg = SEG_5;
                4'd6: seg = SEG_6;
                4'd7: seg = SEG_7;
                4'd8: seg = SEG_8;
                4'd9: seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Serial double-dabble BCD conversion of an 8-bit result plus sign, driving a
// 4-digit multiplexed seven-segment display. Optional: LEADING_ZERO_BLANK_EN.
module result_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    input  logic       neg,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0]       state;
    logic [19:0]      shift_reg;
    logic [19:0]      adjusted;
    logic [2:0]       bit_cnt;
    logic             sign_latch;
    logic [BCD_W-1:0] disp_hund;
    logic [BCD_W-1:0] disp_tens;
    logic [BCD_W-1:0] disp_ones;
    logic             disp_neg;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic             scan_en;
    logic [3:0]       cur_bcd;
    logic             cur_blank;
    logic [6:0]       enc_seg;
    logic [6:0]       seg_next;
    logic             hund_blank;
    logic             tens_blank;

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dp        = 1'b1;
    assign state_dbg = state;

    assign adjusted = {bcd_adjust(shift_reg[19:16]),
                       bcd_adjust(shift_reg[15:12]),
                       bcd_adjust(shift_reg[11:8]),
                       shift_reg[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            sign_latch <= 1'b0;
            disp_hund  <= '0;
            disp_tens  <= '0;
            disp_ones  <= '0;
            disp_neg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg  <= {12'b0, value};
                        sign_latch <= neg;
                        bit_cnt    <= '0;
                        state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    shift_reg <= {adjusted[18:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    disp_hund <= shift_reg[19:16];
                    disp_tens <= shift_reg[15:12];
                    disp_ones <= shift_reg[11:8];
                    disp_neg  <= sign_latch;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign hund_blank = (disp_hund == 4'd0);
    assign tens_blank = hund_blank && (disp_tens == 4'd0);
`else
    assign hund_blank = 1'b0;
    assign tens_blank = 1'b0;
`endif

    always_comb begin
        cur_bcd   = disp_ones;
        cur_blank = 1'b0;
        case (digit_idx)
            2'd0: begin cur_bcd = disp_ones; cur_blank = 1'b0;       end
            2'd1: begin cur_bcd = disp_tens; cur_blank = tens_blank; end
            2'd2: begin cur_bcd = disp_hund; cur_blank = hund_blank; end
            default: begin cur_bcd = 4'd0;   cur_blank = 1'b1;       end
        endcase
    end

    seg7_encode u_encode (
        .bcd   (cur_bcd),
        .blank (cur_blank),
        .seg   (enc_seg)
    );

    assign seg_next = (digit_idx == 2'd3) ? (disp_neg ? SEG_MINUS : SEG_BLANK) : enc_seg;

    // The first wrap only enables scanning so digit 0 is the first one lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            scan_en     <= 1'b0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                scan_en     <= 1'b1;
                if (scan_en) begin
                    digit_idx <= digit_idx + 2'd1;
                end
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (scan_en) begin
                an  <= ~(4'b0001 << digit_idx);
                seg <= seg_next;
            end
        end
    end

endmodule
